// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: a valid/ready read request
// and a response strobe carrying one 32-bit instruction word.
interface instruction_fetch_stage_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64
);

  logic                      outMemReqValid;
  logic [BUS_DATA_WIDTH-1:0] outMemReqAddr;
  logic                      inMemReqReady;
  logic                      inMemRespValid;
  logic [31:0]               inMemRespData;

  // Fetch stage side: issues requests, consumes responses
  modport master (
    output outMemReqValid,
    output outMemReqAddr,
    input  inMemReqReady,
    input  inMemRespValid,
    input  inMemRespData
  );

  // Memory side: accepts requests, returns instruction words
  modport slave (
    input  outMemReqValid,
    input  outMemReqAddr,
    output inMemReqReady,
    output inMemRespValid,
    output inMemRespData
  );

endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, keeps one instruction read in flight, and
// fills the IF/ID register, honouring decode stalls and EX redirects.
// A one-entry skid buffer parks a response that lands while decode stalls.
module instruction_fetch_stage #(
  parameter int unsigned                BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0]  RESET_PC       = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inStall,
  input  logic                          inRedirect,
  input  logic [BUS_DATA_WIDTH-1:0]     inRedirectPc,
  instruction_fetch_stage_if.master     mem,
  output logic                          outIdValid,
  output logic [BUS_DATA_WIDTH-1:0]     outIdPc,
  output logic [31:0]                   outIdIns
);

  localparam int unsigned W     = BUS_DATA_WIDTH;
  localparam int unsigned INS_W = 32;
  localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t              r_state;
  logic [W-1:0]        r_pc;
  logic                r_id_valid;
  logic [W-1:0]        r_id_pc;
  logic [INS_W-1:0]    r_id_ins;
  logic                r_skid_valid;
  logic [W-1:0]        r_skid_pc;
  logic [INS_W-1:0]    r_skid_ins;

  state_t              w_state_nxt;
  logic [W-1:0]        w_pc_nxt;
  logic                w_id_valid_nxt;
  logic [W-1:0]        w_id_pc_nxt;
  logic [INS_W-1:0]    w_id_ins_nxt;
  logic                w_skid_valid_nxt;
  logic [W-1:0]        w_skid_pc_nxt;
  logic [INS_W-1:0]    w_skid_ins_nxt;

  logic                w_req_accept;
  logic [W-1:0]        w_pc_inc;
  logic [W-1:0]        w_redirect_pc;

  assign w_req_accept  = (r_state == S_REQ) && mem.inMemReqReady;
  // PC wraps modulo 2^W, so the top word steps to zero
  assign w_pc_inc      = r_pc + W'(4);
  // Redirect targets are forced onto a word boundary
  assign w_redirect_pc = inRedirectPc & ~W'(3);

  assign mem.outMemReqValid = (r_state == S_REQ);
  assign mem.outMemReqAddr  = r_pc;
  assign outIdValid         = r_id_valid;
  assign outIdPc            = r_id_pc;
  assign outIdIns           = r_id_ins;

  // State, PC, IF/ID and skid registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_ins     <= NOP_INS;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_ins   <= NOP_INS;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_pc      <= w_id_pc_nxt;
      r_id_ins     <= w_id_ins_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_ins   <= w_skid_ins_nxt;
    end
  end

  // Next-state, PC and IF/ID selection; a redirect overrides everything else
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    // A stall freezes IF/ID; otherwise a cycle without delivery is a bubble
    w_id_valid_nxt   = inStall ? r_id_valid : 1'b0;
    w_id_pc_nxt      = r_id_pc;
    w_id_ins_nxt     = r_id_ins;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_ins_nxt   = r_skid_ins;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_req_accept) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.inMemRespValid) begin
          if (inStall) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_pc_nxt    = r_pc;
            w_skid_ins_nxt   = mem.inMemRespData;
            w_state_nxt      = S_FULL;
          end else begin
            w_id_valid_nxt   = 1'b1;
            w_id_pc_nxt      = r_pc;
            w_id_ins_nxt     = mem.inMemRespData;
            w_pc_nxt         = w_pc_inc;
            w_state_nxt      = S_REQ;
          end
        end
      end
      S_FULL: begin
        if (!inStall) begin
          w_id_valid_nxt   = r_skid_valid;
          w_id_pc_nxt      = r_skid_pc;
          w_id_ins_nxt     = r_skid_ins;
          w_skid_valid_nxt = 1'b0;
          w_pc_nxt         = w_pc_inc;
          w_state_nxt      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (mem.inMemRespValid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (inRedirect) begin
      w_pc_nxt         = w_redirect_pc;
      w_id_valid_nxt   = 1'b0;
      w_id_pc_nxt      = r_id_pc;
      w_id_ins_nxt     = r_id_ins;
      w_skid_valid_nxt = 1'b0;
      case (r_state)
        // A request that is (or becomes) outstanding must have its response dropped
        S_REQ:   w_state_nxt = w_req_accept ? S_DRAIN : S_REQ;
        S_WAIT:  w_state_nxt = mem.inMemRespValid ? S_REQ : S_DRAIN;
        S_DRAIN: w_state_nxt = mem.inMemRespValid ? S_REQ : S_DRAIN;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: a memory model answers accepted
// requests, a reference model of PC / IF/ID predicts every cycle, and
// expected deliveries flow through a scoreboard queue.
module tb_instruction_fetch_stage;

  localparam int unsigned W = 64;
  localparam logic [W-1:0] RST_PC = 64'h0;
  localparam logic [31:0]  NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [31:0]  ins;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         inStall;
  logic         inRedirect;
  logic [W-1:0] inRedirectPc;
  logic         outIdValid;
  logic [W-1:0] outIdPc;
  logic [31:0]  outIdIns;

  instruction_fetch_stage_if #(.BUS_DATA_WIDTH(W)) mif ();

  instruction_fetch_stage #(
    .BUS_DATA_WIDTH(W),
    .RESET_PC      (RST_PC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inStall      (inStall),
    .inRedirect   (inRedirect),
    .inRedirectPc (inRedirectPc),
    .mem          (mif),
    .outIdValid   (outIdValid),
    .outIdPc      (outIdPc),
    .outIdIns     (outIdIns)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory model state
  logic         m_pending = 1'b0;
  logic         m_drop    = 1'b0;
  int           m_delay   = 0;
  int unsigned  cfg_lat   = 0;
  logic [W-1:0] mem_addr  = '0;

  // Reference model state
  logic [W-1:0] m_pc      = RST_PC;
  logic [W-1:0] m_acc_pc  = '0;
  logic         m_skid    = 1'b0;
  logic         m_id_valid = 1'b0;
  logic [W-1:0] m_id_pc   = '0;
  logic [31:0]  m_id_ins  = NOP;
  exp_t         sb[$];

  function automatic logic [31:0] mem_word(input logic [W-1:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    if (lo == 32'h4) return 32'hAABB_CCDD;
    return (lo * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: capture pre-edge inputs, advance models, compare IF/ID
  task automatic cycle();
    logic         acc, rsp, stl, rdr, rst, got;
    logic [W-1:0] acc_addr, rdr_pc;
    exp_t         e;
    acc      = mif.outMemReqValid && mif.inMemReqReady;
    acc_addr = mif.outMemReqAddr;
    rsp      = mif.inMemRespValid;
    stl      = inStall;
    rdr      = inRedirect;
    rdr_pc   = inRedirectPc;
    rst      = reset;
    got      = 1'b0;
    @(posedge clk);
    #1;
    if (rsp) begin
      m_pending = 1'b0;
      mif.inMemRespValid = 1'b0;
      mif.inMemRespData  = 32'hDEAD_BEEF;
      if (!m_drop && !rdr && !rst) begin
        sb.push_back('{pc: m_acc_pc, ins: mem_word(m_acc_pc)});
        got = 1'b1;
      end
      m_drop = 1'b0;
    end
    if (acc && !rst) begin
      check("req_addr", acc_addr, m_pc);
      m_pending = 1'b1;
      m_drop    = 1'b0;
      m_delay   = int'(cfg_lat);
      mem_addr  = acc_addr;
      m_acc_pc  = m_pc;
    end
    if (rst) begin
      m_pc = RST_PC;
      if (m_pending) m_drop = 1'b1;
      sb.delete();
      m_skid = 1'b0;
      m_id_valid = 1'b0;
      m_id_pc = '0;
      m_id_ins = NOP;
    end else if (rdr) begin
      m_pc = rdr_pc & ~W'(3);
      if (m_pending) m_drop = 1'b1;
      sb.delete();
      m_skid = 1'b0;
      m_id_valid = 1'b0;
    end else if (stl) begin
      if (got) m_skid = 1'b1;
    end else if (got || m_skid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: delivery expected but queue empty");
      end else begin
        e = sb.pop_front();
        m_id_valid = 1'b1;
        m_id_pc    = e.pc;
        m_id_ins   = e.ins;
        m_pc       = e.pc + W'(4);
      end
      m_skid = 1'b0;
    end else begin
      m_id_valid = 1'b0;
    end
    check("id_valid", outIdValid, m_id_valid);
    check("id_pc", outIdPc, m_id_pc);
    check("id_ins", outIdIns, m_id_ins);
    if (m_pending && !mif.inMemRespValid) begin
      if (m_delay == 0) begin
        mif.inMemRespValid = 1'b1;
        mif.inMemRespData  = mem_word(mem_addr);
      end else begin
        m_delay--;
      end
    end
  endtask

  task automatic wait_req(input string tag, input logic [W-1:0] a);
    for (int i = 0; i < 20; i++) begin
      if (mif.outMemReqValid === 1'b1 && mif.outMemReqAddr === a) return;
      cycle();
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: no request seen, addr %h required %h", tag, mif.outMemReqAddr, a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    inStall = 1'b0;
    inRedirect = 1'b0;
    inRedirectPc = '0;
    mif.inMemReqReady  = 1'b0;
    mif.inMemRespValid = 1'b0;
    mif.inMemRespData  = 32'hDEAD_BEEF;

    // Reset values
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_req_valid", mif.outMemReqValid, 1'b0);
    check("rst_req_addr", mif.outMemReqAddr, RST_PC);
    check("rst_id_ins", outIdIns, NOP);

    // Streaming with zero-wait memory, then ready held low at pc=8
    mif.inMemReqReady = 1'b1;
    wait_req("stream_req8", 64'h8);
    mif.inMemReqReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_valid", mif.outMemReqValid, 1'b1);
      check("hold_addr", mif.outMemReqAddr, 64'h8);
    end
    mif.inMemReqReady = 1'b1;
    repeat (6) cycle();

    // Stall while the response for pc=4 lands
    do_reset();
    wait_req("stall_req4", 64'h4);
    cycle();
    inStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_no_req", mif.outMemReqValid, 1'b0);
    end
    inStall = 1'b0;
    cycle();
    check("release_valid", outIdValid, 1'b1);
    check("release_pc", outIdPc, 64'h4);
    check("release_ins", outIdIns, 64'hAABB_CCDD);
    check("release_req", mif.outMemReqValid, 1'b1);
    check("release_addr", mif.outMemReqAddr, 64'h8);
    repeat (4) cycle();

    // Redirect while waiting on pc=4
    do_reset();
    wait_req("rd4_req4", 64'h4);
    cfg_lat = 2;
    cycle();
    cfg_lat = 0;
    inRedirect = 1'b1;
    inRedirectPc = 64'h103;
    cycle();
    inRedirect = 1'b0;
    check("rd4_bubble", outIdValid, 1'b0);
    wait_req("rd4_req100", 64'h100);
    cycle();
    cycle();
    check("rd4_id_valid", outIdValid, 1'b1);
    check("rd4_id_pc", outIdPc, 64'h100);

    // Redirect in the same cycle as the response
    do_reset();
    wait_req("rd5_req4", 64'h4);
    cycle();
    inRedirect = 1'b1;
    inRedirectPc = 64'h200;
    cycle();
    inRedirect = 1'b0;
    check("rd5_req", mif.outMemReqValid, 1'b1);
    check("rd5_addr", mif.outMemReqAddr, 64'h200);
    check("rd5_bubble", outIdValid, 1'b0);
    cycle();
    cycle();
    check("rd5_id_valid", outIdValid, 1'b1);
    check("rd5_id_pc", outIdPc, 64'h200);

    // Reset mid-WAIT with a late response
    do_reset();
    wait_req("rst6_req4", 64'h4);
    cfg_lat = 2;
    cycle();
    cfg_lat = 0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    mif.inMemReqReady = 1'b0;
    check("rst6_ins", outIdIns, NOP);
    cycle();
    cycle();
    check("rst6_req", mif.outMemReqValid, 1'b1);
    check("rst6_addr", mif.outMemReqAddr, RST_PC);
    mif.inMemReqReady = 1'b1;
    cycle();
    check("rst6_ins_hold", outIdIns, NOP);
    cycle();
    check("rst6_first_valid", outIdValid, 1'b1);
    check("rst6_first_pc", outIdPc, RST_PC);

    // PC wrap at the top of the address space
    inRedirect = 1'b1;
    inRedirectPc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    inRedirect = 1'b0;
    wait_req("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    wait_req("wrap_zero", 64'h0);

    // Random stall / ready / latency / redirect mix
    for (int c = 0; c < 300; c++) begin
      inStall = ($urandom_range(0, 9) < 3);
      mif.inMemReqReady = ($urandom_range(0, 9) < 7);
      cfg_lat = $urandom_range(0, 3);
      inRedirect = ($urandom_range(0, 19) == 0);
      inRedirectPc = {$urandom, $urandom};
      cycle();
    end
    inStall = 1'b0;
    inRedirect = 1'b0;
    mif.inMemReqReady = 1'b1;
    cfg_lat = 0;
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage directly upstream of the hazard detection unit and the decode stage.
- Owns the PC and issues one instruction-memory read at a time over a valid/ready request plus a response strobe.
- Writes the IF/ID pipeline register (pc, instruction, valid) that the hazard unit inspects.
- Obeys the hazard unit's stall and the EX-stage redirect for taken branches and jumps.

Parameters:
BUS_DATA_WIDTH, 64, width of the PC and the memory address.
RESET_PC, 0, PC loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
inStall  input  1  1 = decode holds: freeze IF/ID and do not advance PC.
inRedirect  input  1  taken branch/jump from EX; one-cycle pulse.
inRedirectPc  input  BUS_DATA_WIDTH  redirect target.
outMemReqValid  output  1  instruction read request valid.
outMemReqAddr  output  BUS_DATA_WIDTH  request address (= PC).
inMemReqReady  input  1  memory accepts request when valid&&ready.
inMemRespValid  input  1  read data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
inMemRespData  input  32  instruction word.
outIdValid  output  1  IF/ID holds a real instruction.
outIdPc  output  BUS_DATA_WIDTH  PC of IF/ID instruction.
outIdIns  output  32  IF/ID instruction.

Behaviour:
- Reset (synchronous, any state): pc=RESET_PC, state=IDLE, outMemReqValid=0, outIdValid=0, outIdPc=0, outIdIns=32'h00000013 (NOP), skid buffer empty.
- States: IDLE, REQ, WAIT, FULL, DRAIN. outMemReqValid=1 only in REQ; outMemReqAddr=pc at all times.
- IDLE: go to REQ next cycle. Ignore inMemRespValid.
- REQ: hold valid and address stable until inMemReqReady. On valid&&ready go to WAIT. Ignore inMemRespValid.
- WAIT on inMemRespValid:
  - inStall=0: IF/ID <= {1, pc, data}; pc <= pc+4; go to REQ.
  - inStall=1: capture {pc, data} into a one-entry skid buffer; go to FULL.
- FULL: IF/ID holds while inStall=1. First cycle with inStall=0: IF/ID <= buffer, valid=1; pc <= pc+4; go to REQ.
- IF/ID update rule:
  - inStall=1: IF/ID unchanged, except on redirect.
  - inStall=0 with no instruction delivered this cycle: outIdValid <= 0 (bubble); outIdPc and outIdIns keep their values.
- Redirect (priority over stall and over a response in the same cycle):
  - Always: pc <= {inRedirectPc[W-1:2], 2'b00}; outIdValid <= 0; skid buffer emptied.
  - REQ without acceptance this cycle: stay in REQ (new address next cycle).
  - REQ with valid&&ready this cycle: go to DRAIN.
  - WAIT with no response this cycle: go to DRAIN.
  - WAIT with response this cycle: drop data, go to REQ.
  - FULL or IDLE: go to REQ.
  - DRAIN: stay in DRAIN; pc updated.
- DRAIN: discard the next inMemRespValid, then go to REQ. A redirect in the same cycle as the drained response goes to REQ with the new pc.
- The outstanding request's address may change only on redirect.
- PC arithmetic: modulo 2^BUS_DATA_WIDTH; 0x...FFFC + 4 = 0.
- Throughput: with zero-wait memory (ready=1, response next cycle), one instruction per 2 cycles (REQ, WAIT). Latency from request acceptance to outIdValid is response latency + 1 edge.
- At most one request outstanding at any time. Reset mid-WAIT abandons the request; late responses arrive in IDLE or REQ and are ignored.

Test Plan:
1. RESET_PC=0, ready=1, response 1 cycle after accept, inStall=0 -> requests at 0,4,8,12. outIdValid pulses every 2nd cycle with outIdPc 0,4,8 and matching outIdIns; bubbles between.
2. inMemReqReady low 3 cycles in REQ at pc=8 -> outMemReqValid=1 and outMemReqAddr=8 stable all 3 cycles; single acceptance on 4th.
3. inStall=1 when response 0xAABBCCDD for pc=4 arrives, held 3 cycles -> IF/ID keeps previous instruction, no new request. On release, IF/ID={1,4,0xAABBCCDD} next edge and request at 8 the cycle after.
4. Redirect to 0x103 while in WAIT for pc=4 -> outIdValid=0, pending response discarded, next request addr 0x100, then IF/ID pc=0x100.
5. Redirect to 0x200 in the same cycle as the response arrives -> data dropped, REQ at 0x200 next cycle, no extra discarded response.
6. Reset asserted while in WAIT, response arrives 2 cycles after reset release -> ignored; first request at RESET_PC, outIdIns=0x00000013 until first delivery. Also: pc=0x...FFFC fetch -> next request at 0.
